// File: rtl/suite_pkg.sv
// suite_pkg: VRAM geometry and fill-engine state encoding shared across the 240p suite.
package suite_pkg;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int VRAM_WORDS = 131072;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fill_state_t;
endpackage

// File: rtl/vram_fill_engine.sv
// vram_fill_engine: validates fill requests and walks the range, requesting a write on free cycles.
module vram_fill_engine import suite_pkg::*; #(
  parameter int AW = suite_pkg::AW,
  parameter int DW = suite_pkg::DW,
  parameter int VRAM_WORDS = suite_pkg::VRAM_WORDS,
  parameter int BLANK_ONLY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ioctl_wr,
  input  logic          v_blank,
  input  logic          fill_start,
  input  logic          fill_abort,
  input  logic [AW-1:0] fill_base,
  input  logic [AW:0]   fill_len,
  input  logic [DW-1:0] fill_data,
  output logic          req,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] req_data,
  output logic          busy,
  output logic          done,
  output logic          err
);
  fill_state_t state;
  logic [AW:0] rem;
  logic over;
  // one extra bit so a huge fill_len cannot wrap the bound check
  assign over = ({2'b0, fill_base} + {1'b0, fill_len}) > (AW+2)'(VRAM_WORDS);
  assign req = state == RUN && !ioctl_wr && (v_blank || BLANK_ONLY == 0) && !fill_abort;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      req_addr <= '0;
      rem <= '0;
      req_data <= '0;
      err <= 1'b0;
    end else begin
      err <= fill_start && (state != IDLE || (fill_len != '0 && over));
      if (state == IDLE) begin
        if (fill_start && fill_len == '0) state <= DONE;
        else if (fill_start && !over) begin
          state <= RUN;
          req_addr <= fill_base;
          rem <= fill_len;
          req_data <= fill_data;
        end
      end else if (state == RUN) begin
        if (fill_abort) state <= IDLE;
        else if (req) begin
          req_addr <= req_addr + 1'b1;
          rem <= rem - 1'b1;
          if (rem == (AW+1)'(1)) state <= DONE;
        end
      end else state <= IDLE;
    end
endmodule

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: owns VRAM write port B; ioctl download always wins, fill uses leftover cycles.
module vram_write_arbiter #(
  parameter int AW = suite_pkg::AW,
  parameter int DW = suite_pkg::DW,
  parameter int VRAM_WORDS = suite_pkg::VRAM_WORDS,
  parameter int BLANK_ONLY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_data,
  input  logic          v_blank,
  input  logic          fill_start,
  input  logic          fill_abort,
  input  logic [AW-1:0] fill_base,
  input  logic [AW:0]   fill_len,
  input  logic [DW-1:0] fill_data,
  output logic          vram_we,
  output logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_data,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          fill_err
);
  logic req;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  vram_fill_engine #(.AW(AW), .DW(DW), .VRAM_WORDS(VRAM_WORDS), .BLANK_ONLY(BLANK_ONLY)) u_fill (
    .clk(clk), .reset(reset), .ioctl_wr(ioctl_wr), .v_blank(v_blank),
    .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base),
    .fill_len(fill_len), .fill_data(fill_data), .req(req), .req_addr(req_addr),
    .req_data(req_data), .busy(fill_busy), .done(fill_done), .err(fill_err)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      vram_we <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= ioctl_wr | req;
      vram_addr <= ioctl_wr ? ioctl_addr : req_addr;
      vram_data <= ioctl_wr ? ioctl_data : req_data;
    end
endmodule
